// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addsub_pkg
// Description : Shared types and helpers for the nibble-serial add/sub
//               sequencer (FSM states, opcodes, slice width, saturation).
// Revision    : 1.0  initial release
// ============================================================================
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  localparam int   NIB_W  = 4;

  // Signed saturation bound for a w-bit result: neg=1 -> 100..0, neg=0 -> 011..1.
  // Returned zero-extended to 32 bits; callers slice to their own width.
  function automatic logic [31:0] sat_value(input logic neg, input int unsigned w);
    logic [31:0] v_msb;
    v_msb = 32'h1 << (w - 1);
    return neg ? v_msb : (v_msb - 32'h1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_share_ctrl_nibble_addsub.sv
`default_nettype none
// ============================================================================
// Module      : nibble_addsub (+ helper addsub_fa)
// Description : 4-bit ripple adder slice built from four full adders.
//               Exposes the carry into bit 3 so the caller can derive
//               signed overflow of the most significant nibble.
// Revision    : 1.0  initial release
// ============================================================================
module addsub_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module nibble_addsub
  import addsub_pkg::*;
(
  input  logic [NIB_W-1:0] x,
  input  logic [NIB_W-1:0] y,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             c3,
  output logic             cout
);

  logic [NIB_W:0] w_c;

  assign w_c[0] = cin;

  generate
    for (genvar gi = 0; gi < NIB_W; gi++) begin : g_bit
      addsub_fa u_fa (
        .a  (x[gi]),
        .b  (y[gi]),
        .ci (w_c[gi]),
        .s  (s[gi]),
        .co (w_c[gi+1])
      );
    end
  endgenerate

  assign c3   = w_c[NIB_W-1];
  assign cout = w_c[NIB_W];

endmodule
`default_nettype wire

// File: rtl/addsub_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : addsub_share_ctrl
// Description : Round-robin arbiter and nibble-serial sequencer sharing one
//               4-bit add/sub slice between two requesters. A W = 4*NIB bit
//               operation runs LSB nibble first, one nibble per clock.
//               Optional build macro ADDSUB_SAT_EN: on signed overflow the
//               final result is replaced by the signed saturation bound.
// Revision    : 1.0  initial release
// ============================================================================
module addsub_share_ctrl
  import addsub_pkg::*;
#(
  parameter int NIB = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             op0,
  input  logic [4*NIB-1:0] a0,
  input  logic [4*NIB-1:0] b0,
  input  logic             req1,
  input  logic             op1,
  input  logic [4*NIB-1:0] a1,
  input  logic [4*NIB-1:0] b1,
  output logic             ack0,
  output logic             ack1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [4*NIB-1:0] result,
  output logic             c_out,
  output logic             over_flow
);

  localparam int         W        = NIB * NIB_W;
  localparam logic [2:0] IDX_LAST = 3'(NIB - 1);

  state_t           r_state;
  logic             r_last;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic             r_op;
  logic             r_id;
  logic             r_carry;
  logic [2:0]       r_idx;
  logic [W-1:0]     r_result;
  logic             r_cout;
  logic             r_ovf;
  logic             r_done;
  logic             r_done_id;

  logic             w_grant;
  logic             w_gid;
  logic [NIB_W-1:0] w_x;
  logic [NIB_W-1:0] w_y;
  logic [NIB_W-1:0] w_s;
  logic             w_c3;
  logic             w_cout;

  // Arbitration: a lone request wins; under contention the requester that
  // did not win last time is granted.
  always_comb begin
    w_grant = (r_state == IDLE) && (req0 || req1);
    w_gid   = (req0 && req1) ? ~r_last : req1;
  end

  // The ack is a same-cycle pulse: operands are captured on the edge ending it.
  assign ack0 = w_grant && !w_gid;
  assign ack1 = w_grant &&  w_gid;

  // Operand nibble selection; subtract inverts b and injects carry-in = 1.
  always_comb begin
    w_x = r_a[r_idx*NIB_W +: NIB_W];
    w_y = r_b[r_idx*NIB_W +: NIB_W] ^ {NIB_W{r_op}};
  end

  nibble_addsub u_slice (
    .x    (w_x),
    .y    (w_y),
    .cin  (r_carry),
    .s    (w_s),
    .c3   (w_c3),
    .cout (w_cout)
  );

  // Sequencer FSM with registered status/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= OP_ADD;
      r_id      <= 1'b0;
      r_carry   <= 1'b0;
      r_idx     <= 3'd0;
      r_result  <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_a     <= w_gid ? a1  : a0;
            r_b     <= w_gid ? b1  : b0;
            r_op    <= w_gid ? op1 : op0;
            r_carry <= w_gid ? op1 : op0;
            r_id    <= w_gid;
            r_last  <= w_gid;
            r_idx   <= 3'd0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_result[r_idx*NIB_W +: NIB_W] <= w_s;
          r_carry <= w_cout;
          if (r_idx == IDX_LAST) begin
            r_cout    <= w_cout;
            r_ovf     <= w_c3 ^ w_cout;
            r_done    <= 1'b1;
            r_done_id <= r_id;
            r_state   <= DONE;
`ifdef ADDSUB_SAT_EN
            // Equal effective operand signs with a negative raw sum means
            // positive overflow; every other overflow saturates negative.
            if (w_c3 ^ w_cout) begin
              r_result <= W'(sat_value(
                  !(!(r_a[W-1] ^ r_b[W-1] ^ r_op) && w_s[NIB_W-1]), W));
            end
`endif
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign done_id   = r_done_id;
  assign result    = r_result;
  assign c_out     = r_cout;
  assign over_flow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_addsub_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_share_ctrl
// Description : Self-checking bench for addsub_share_ctrl (NIB = 2) using
//               directed vectors, arbitration/reset scenarios and random
//               operations against an arithmetic reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_addsub_share_ctrl;

  localparam int NIB = 2;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0, op0, req1, op1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         ack0, ack1, busy, done, done_id, c_out, over_flow;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_errors = 0;

  addsub_share_ctrl #(.NIB(NIB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .op0       (op0),
    .a0        (a0),
    .b0        (b0),
    .req1      (req1),
    .op1       (op1),
    .a1        (a1),
    .b1        (b1),
    .ack0      (ack0),
    .ack1      (ack1),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .result    (result),
    .c_out     (c_out),
    .over_flow (over_flow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  task automatic model(input bit op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output bit c, output bit v);
    int ua, ub, sa, sb, ss;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= (1 << (W-1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W-1))) ? ub - (1 << W) : ub;
    if (op) begin
      r  = W'(ua - ub);
      c  = (ua >= ub);
      ss = sa - sb;
    end else begin
      r  = W'(ua + ub);
      c  = (ua + ub) >= (1 << W);
      ss = sa + sb;
    end
    v = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
`ifdef ADDSUB_SAT_EN
    if (v) r = (ss > 0) ? W'((1 << (W-1)) - 1) : W'(1 << (W-1));
`endif
  endtask

  // Wait (bounded) for an ack at a negedge; returns 1 if seen.
  task automatic wait_ack(output bit got);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (ack0 || ack1) got = 1'b1;
    end
    chk("ack_seen", 32'(got), 32'd1);
  endtask

  // Issue one operation from requester id and check timing and result.
  task automatic run_op(input bit id, input bit op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit pulse_other);
    logic [W-1:0] er;
    bit ec, ev, got;
    model(op, a, b, er, ec, ev);
    @(posedge clk); #1;
    if (id) begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    else    begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
    wait_ack(got);
    chk("ack_id", {30'd0, ack1, ack0}, id ? 32'd2 : 32'd1);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
    for (int k = 0; k < NIB; k++) begin
      if (pulse_other) begin
        if (id) req0 = (k == 0); else req1 = (k == 0);
      end
      @(negedge clk);
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_no_done", 32'(done), 32'd0);
      chk("run_no_ack", {30'd0, ack1, ack0}, 32'd0);
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("done", 32'(done), 32'd1);
    chk("done_id", 32'(done_id), 32'(id));
    chk("result", 32'(result), 32'(er));
    chk("c_out", 32'(c_out), 32'(ec));
    chk("over_flow", 32'(over_flow), 32'(ev));
  endtask

  initial begin
    bit got;
    logic [W-1:0] er;
    bit ec, ev;

    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ack", {30'd0, ack1, ack0}, 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", {29'd0, done_id, c_out, over_flow}, 32'd0);
    rst_n = 1'b1;

    // Directed vectors.
    run_op(1'b0, 1'b1, 8'h35, 8'h12, 1'b0);
    chk("vec1_result", 32'(result), 32'h23);
    run_op(1'b1, 1'b1, 8'h70, 8'h90, 1'b0);
    run_op(1'b0, 1'b0, 8'hFF, 8'h01, 1'b0);
    chk("vec3_result", 32'(result), 32'h00);
    chk("vec3_cout", 32'(c_out), 32'd1);
    run_op(1'b0, 1'b1, 8'h5A, 8'h00, 1'b0);
    chk("sub_zero_cout", 32'(c_out), 32'd1);

    // Other requester pulsed while busy is ignored.
    run_op(1'b0, 1'b0, 8'h12, 8'h34, 1'b1);
    run_op(1'b1, 1'b1, 8'h01, 8'h02, 1'b1);

    // Reset during the first RUN cycle aborts the operation.
    @(posedge clk); #1;
    req0 = 1'b1; op0 = 1'b1; a0 = 8'h35; b0 = 8'h12;
    wait_ack(got);
    @(posedge clk); #1;
    req0 = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_flags", {29'd0, done, c_out, over_flow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end

    // Both requesters held: round-robin must alternate starting with 0.
    @(posedge clk); #1;
    op0 = 1'b0; a0 = 8'h11; b0 = 8'h22;
    op1 = 1'b1; a1 = 8'h80; b1 = 8'h01;
    req0 = 1'b1; req1 = 1'b1;
    for (int n = 0; n < 4; n++) begin
      wait_ack(got);
      chk("rr_ack", {30'd0, ack1, ack0}, (n % 2) ? 32'd2 : 32'd1);
      for (int k = 0; k < NIB; k++) begin
        @(negedge clk);
        chk("rr_no_done", 32'(done), 32'd0);
      end
      @(negedge clk);
      chk("rr_done", 32'(done), 32'd1);
      chk("rr_done_id", 32'(done_id), 32'(n % 2));
      if (n % 2) model(1'b1, 8'h80, 8'h01, er, ec, ev);
      else       model(1'b0, 8'h11, 8'h22, er, ec, ev);
      chk("rr_result", 32'(result), 32'(er));
      chk("rr_ovf", 32'(over_flow), 32'(ev));
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("idle_after_rr", 32'(busy), 32'd0);

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      run_op(1'($urandom), 1'($urandom), W'($urandom), W'($urandom),
             1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time guard.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
